// File: rtl/image_pkg.sv
// Shared types and constants for the image option-mux mode sequencer.
package image_pkg;

    localparam int MODE_W      = 3;
    localparam int FRAME_CNT_W = 12;

    localparam logic [MODE_W-1:0] MODE_BLANK       = 3'd7;
    localparam logic [MODE_W-1:0] MODE_LAST_ACTIVE = 3'd6;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        IN_FRAME   = 2'd1,
        COMMIT     = 2'd2
    } seq_state_e;

    // Auto-cycle successor: 0..6 wrapping to 0, blank (7) also goes to 0.
    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
        if (m >= MODE_LAST_ACTIVE) begin
            return '0;
        end
        return m + 3'd1;
    endfunction

endpackage

// File: rtl/image_mode_sequencer_frame_edge_detect.sv
// Registers the frame-valid level and flags its rising and falling edges.
module frame_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_valid_i,
    output logic rise_o,
    output logic fall_o
);

    logic lv_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lv_q <= 1'b0;
        end else begin
            lv_q <= line_valid_i;
        end
    end

    assign rise_o = line_valid_i & ~lv_q;
    assign fall_o = lv_q & ~line_valid_i;

endmodule

// File: rtl/image_mode_sequencer.sv
// Frame-synchronous mode select for the image_processor option mux; mode changes land only in blanking.
// Define MODE_SEQ_AUTO_EN to build the auto-cycle counter (otherwise iAutoEn is ignored).
module image_mode_sequencer
    import image_pkg::*;
#(
    parameter int FRAME_DIV  = 60,
    parameter int RESET_MODE = 0
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iLineValid,
    input  logic [MODE_W-1:0]      iReqMode,
    input  logic                   iReqStrobe,
    input  logic                   iAutoEn,
    output logic [MODE_W-1:0]      oMode,
    output logic                   oPending,
    output logic                   oSwitched,
    output logic [FRAME_CNT_W-1:0] oFrameCount
);

    seq_state_e             state_q, state_d;
    logic [MODE_W-1:0]      mode_q, mode_d;
    logic [MODE_W-1:0]      pend_val_q, pend_val_d;
    logic                   pend_q, pend_d;
    logic                   switched_q, switched_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   do_manual;
    logic                   line_rise;
    logic                   line_fall;
    logic                   unused_rise;

    // The level, not the rise, starts a frame so one already running at reset release is still tracked.
    assign unused_rise = line_rise;

`ifdef MODE_SEQ_AUTO_EN
    localparam logic [FRAME_CNT_W-1:0] AUTO_LAST = FRAME_CNT_W'(FRAME_DIV - 1);
    logic [FRAME_CNT_W-1:0] auto_cnt_q, auto_cnt_d;
`else
    localparam int unused_frame_div = FRAME_DIV;
    logic unused_auto_en;
    assign unused_auto_en = iAutoEn;
`endif

    frame_edge_detect u_edge (
        .clk_i        (iClk),
        .rst_ni       (iRst),
        .line_valid_i (iLineValid),
        .rise_o       (line_rise),
        .fall_o       (line_fall)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        pend_d      = pend_q;
        pend_val_d  = pend_val_q;
        switched_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        do_manual   = 1'b0;
`ifdef MODE_SEQ_AUTO_EN
        auto_cnt_d  = auto_cnt_q;
`endif
        unique case (state_q)
            WAIT_FRAME: begin
                if (iLineValid) begin
                    state_d = IN_FRAME;
                end else if (pend_q) begin
                    do_manual = 1'b1;
                end
            end
            IN_FRAME: begin
                if (line_fall) begin
                    state_d     = COMMIT;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                end
            end
            COMMIT: begin
                state_d = WAIT_FRAME;
                if (pend_q) begin
                    do_manual = 1'b1;
                end
`ifdef MODE_SEQ_AUTO_EN
                else if (iAutoEn && (auto_cnt_q == AUTO_LAST)) begin
                    mode_d     = next_mode(mode_q);
                    auto_cnt_d = '0;
                    switched_d = 1'b1;
                end else begin
                    auto_cnt_d = auto_cnt_q + FRAME_CNT_W'(1);
                end
`endif
            end
            default: state_d = WAIT_FRAME;
        endcase

        if (do_manual) begin
            mode_d     = pend_val_q;
            pend_d     = 1'b0;
            switched_d = 1'b1;
`ifdef MODE_SEQ_AUTO_EN
            auto_cnt_d = '0;
`endif
        end
`ifdef MODE_SEQ_AUTO_EN
        if (!iAutoEn) begin
            auto_cnt_d = '0;
        end
`endif
        // A strobe always lands in the pending register, after any commit of the old value this cycle.
        if (iReqStrobe) begin
            pend_val_d = iReqMode;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q     <= WAIT_FRAME;
            mode_q      <= MODE_W'(RESET_MODE);
            pend_q      <= 1'b0;
            pend_val_q  <= '0;
            switched_q  <= 1'b0;
            frame_cnt_q <= '0;
`ifdef MODE_SEQ_AUTO_EN
            auto_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            pend_val_q  <= pend_val_d;
            switched_q  <= switched_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef MODE_SEQ_AUTO_EN
            auto_cnt_q  <= auto_cnt_d;
`endif
        end
    end

    assign oMode       = mode_q;
    assign oPending    = pend_q;
    assign oSwitched   = switched_q;
    assign oFrameCount = frame_cnt_q;

endmodule

// File: tb/tb_image_mode_sequencer.sv
// Directed bench for image_mode_sequencer with RESET_MODE=3, FRAME_DIV=2.
module tb_image_mode_sequencer;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iLineValid;
    logic [2:0]  iReqMode;
    logic        iReqStrobe;
    logic        iAutoEn;
    logic [2:0]  oMode;
    logic        oPending;
    logic        oSwitched;
    logic [11:0] oFrameCount;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_fc = 0;
    int sw_cnt = 0;
    int pulses;
    int sw_base;

    image_mode_sequencer #(
        .FRAME_DIV  (2),
        .RESET_MODE (3)
    ) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iLineValid  (iLineValid),
        .iReqMode    (iReqMode),
        .iReqStrobe  (iReqStrobe),
        .iAutoEn     (iAutoEn),
        .oMode       (oMode),
        .oPending    (oPending),
        .oSwitched   (oSwitched),
        .oFrameCount (oFrameCount)
    );

    always #5 iClk = ~iClk;

    always @(negedge iClk) begin
        if (iRst && oSwitched) sw_cnt++;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic strobe(input logic [2:0] m);
        iReqMode   = m;
        iReqStrobe = 1'b1;
        tick();
        iReqStrobe = 1'b0;
    endtask

    task automatic do_frame();
        iLineValid = 1'b1;
        repeat (3) tick();
        iLineValid = 1'b0;
        repeat (3) tick();
        exp_fc++;
    endtask

    initial begin
        iRst = 1'b0; iLineValid = 1'b0; iReqMode = 3'd0; iReqStrobe = 1'b0; iAutoEn = 1'b0;
        tick(); tick();
        chk("rst_mode", oMode, 3);
        chk("rst_pend", oPending, 0);
        chk("rst_sw", oSwitched, 0);
        chk("rst_fc", oFrameCount, 0);
        iRst = 1'b1;
        tick();
        chk("rel_mode", oMode, 3);

        // Mid-frame request commits one cycle after COMMIT.
        iLineValid = 1'b1;
        tick(); tick();
        strobe(3'd5);
        chk("t1_pend", oPending, 1);
        chk("t1_hold", oMode, 3);
        tick(); tick();
        chk("t1_hold2", oMode, 3);
        iLineValid = 1'b0;
        tick();
        exp_fc++;
        chk("t1_fc", oFrameCount, exp_fc);
        chk("t1_commit_mode", oMode, 3);
        chk("t1_commit_sw", oSwitched, 0);
        tick();
        chk("t1_mode", oMode, 5);
        chk("t1_sw", oSwitched, 1);
        chk("t1_pend_clr", oPending, 0);
        tick();
        chk("t1_sw_once", oSwitched, 0);

        // Two requests in one frame: last wins, one pulse.
        iLineValid = 1'b1;
        tick();
        strobe(3'd2);
        tick();
        strobe(3'd4);
        tick();
        chk("t2_hold", oMode, 5);
        chk("t2_pend", oPending, 1);
        iLineValid = 1'b0;
        pulses = 0;
        repeat (4) begin
            tick();
            pulses += int'(oSwitched);
        end
        exp_fc++;
        chk("t2_mode", oMode, 4);
        chk("t2_pulses", pulses, 1);
        chk("t2_fc", oFrameCount, exp_fc);

        // Blanking request commits on the next edge.
        strobe(3'd1);
        chk("t3_pend", oPending, 1);
        chk("t3_hold", oMode, 4);
        tick();
        chk("t3_mode", oMode, 1);
        chk("t3_sw", oSwitched, 1);
        chk("t3_pend_clr", oPending, 0);

        // Request coinciding with frame start waits for frame end.
        iLineValid = 1'b1;
        strobe(3'd6);
        chk("t4_pend", oPending, 1);
        repeat (3) tick();
        chk("t4_hold", oMode, 1);
        chk("t4_pend2", oPending, 1);
        iLineValid = 1'b0;
        tick();
        exp_fc++;
        chk("t4_commit_hold", oMode, 1);
        tick();
        chk("t4_mode", oMode, 6);
        chk("t4_sw", oSwitched, 1);
        tick();

        // Request in the COMMIT cycle lands one cycle later.
        iLineValid = 1'b1;
        tick(); tick();
        iLineValid = 1'b0;
        tick();
        exp_fc++;
        strobe(3'd2);
        chk("t5_hold", oMode, 6);
        chk("t5_nosw", oSwitched, 0);
        chk("t5_pend", oPending, 1);
        tick();
        chk("t5_mode", oMode, 2);
        chk("t5_sw", oSwitched, 1);
        chk("t5_fc", oFrameCount, exp_fc);

        // Same-mode request still pulses.
        tick();
        strobe(3'd2);
        tick();
        chk("t6_mode", oMode, 2);
        chk("t6_sw", oSwitched, 1);
        tick();

`ifdef MODE_SEQ_AUTO_EN
        strobe(3'd6);
        tick();
        chk("a_start", oMode, 6);
        iAutoEn = 1'b1;
        do_frame();
        chk("a_f1", oMode, 6);
        do_frame();
        chk("a_f2", oMode, 0);
        do_frame(); do_frame();
        chk("a_f4", oMode, 1);
        iLineValid = 1'b1;
        tick();
        strobe(3'd7);
        tick();
        iLineValid = 1'b0;
        repeat (3) tick();
        exp_fc++;
        chk("a_manual", oMode, 7);
        do_frame();
        chk("a_after1", oMode, 7);
        do_frame();
        chk("a_after2", oMode, 0);
        iAutoEn = 1'b0;
`else
        iAutoEn = 1'b1;
        sw_base = sw_cnt;
        do_frame(); do_frame(); do_frame();
        chk("noauto_mode", oMode, 2);
        chk("noauto_sw", sw_cnt - sw_base, 0);
        iAutoEn = 1'b0;
`endif
        chk("fc_total", oFrameCount, exp_fc);

        // Asynchronous reset mid-frame.
        iLineValid = 1'b1;
        tick();
        strobe(3'd5);
        #2;
        iRst = 1'b0;
        #1;
        chk("ar_mode", oMode, 3);
        chk("ar_pend", oPending, 0);
        chk("ar_fc", oFrameCount, 0);
        tick();
        iRst = 1'b1;
        tick(); tick();
        iLineValid = 1'b0;
        repeat (3) tick();
        chk("ar_fc1", oFrameCount, 1);
        chk("ar_mode_kept", oMode, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/image_mode_sequencer.md
# image_mode_sequencer

- Frame-synchronous controller for the `image_processor` option mux.
- Accepts mode requests from the board (keys/switches) and optionally auto-cycles through the processing options every N frames.
- Drives `oMode` onto `image_processor` `iDebug[2:0]`.
- Commits every mode change only in blanking (after `iLineValid` falls), so the output never switches mid-frame.

## Interface
- `FRAME_DIV`, 60: completed frames between auto-cycle steps; legal 1..4095.
- `RESET_MODE`, 0: value of `oMode` after reset; 0..7.
- `iClk`  in  1  pixel clock, same domain as `image_processor`.
- `iRst`  in  1  reset, asynchronous, active-low.
- `iLineValid`  in  1  frame-valid from the camera path; high for the whole active frame.
- `iReqMode`  in  3  requested option.
- `iReqStrobe`  in  1  one-cycle pulse; captures `iReqMode` (pulse is already debounced upstream).
- `iAutoEn`  in  1  level; enables auto-cycling.
- `oMode`  out  3  committed option select, registered.
- `oPending`  out  1  a manual request is waiting for a boundary.
- `oSwitched`  out  1  one-cycle pulse on every commit that changes or reloads `oMode`.
- `oFrameCount`  out  12  completed frames since reset; wraps 4095 → 0.

## Operation
- States:
  - `WAIT_FRAME`: blanking.
  - `IN_FRAME`: `iLineValid` high.
  - `COMMIT`: one cycle, entered after `iLineValid` falls.
- Transitions:
  - `WAIT_FRAME` → `IN_FRAME` when `iLineValid` = 1.
  - `IN_FRAME` → `COMMIT` when `iLineValid` = 0; `oFrameCount` increments on this edge.
  - `COMMIT` → `WAIT_FRAME` unconditionally.
- Request capture:
  - `iReqStrobe` in any state loads the pending register with `iReqMode` and sets `oPending`.
  - A second strobe before commit overwrites the pending value (last wins).
- In `COMMIT`, priority is:
  - (1) `oPending` = 1: `oMode` ← pending value, `oPending` ← 0, auto counter ← 0.
  - (2) `iAutoEn` = 1 and auto counter = `FRAME_DIV`-1: `oMode` ← next mode, auto counter ← 0.
  - (3) Otherwise: auto counter increments.
- Next-mode rule:
  - Sequence is 0..6, wrapping 6 → 0; mode 7 (blank) is skipped.
  - If `oMode` = 7, the next mode is 0.
- Immediate commit:
  - In `WAIT_FRAME` with `oPending` = 1 and `iLineValid` = 0 in the same cycle, the pending value commits immediately, with the same effects as case (1).
  - If `iLineValid` = 1 that cycle, the state goes to `IN_FRAME` and the request stays pending.
- `iAutoEn` = 0 holds the auto counter at 0.
- `oSwitched` pulses on case (1) and case (2) commits, including a manual request equal to the current mode.
- A strobe in the `COMMIT` cycle is not applied in that commit; it becomes pending and commits in the following `WAIT_FRAME` cycle if `iLineValid` is low.

## Timing
- Reset values:
  - `oMode` = `RESET_MODE`.
  - `oPending`, `oSwitched` = 0; `oFrameCount` = 0.
  - Auto counter = 0; pending register = 0; state = `WAIT_FRAME`.
- Frame-end latency:
  - Edge k samples `iLineValid` = 0 in `IN_FRAME`; state becomes `COMMIT` and `oFrameCount` updates after edge k.
  - `oMode` and `oSwitched` update after edge k+1.
- Pending latency: `oPending` is 1 the cycle after the strobe edge.
- Blanking latency:
  - A strobe sampled at edge j in `WAIT_FRAME`, with `iLineValid` low at edges j and j+1, commits at edge j+1.
  - `oMode` is valid the cycle after edge j+1.
- `oMode` is constant for every cycle `iLineValid` = 1.
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronously); after release the block waits in `WAIT_FRAME`.

## Configuration
- `MODE_SEQ_AUTO_EN` defined:
  - Auto counter, priority case (2) and the `iAutoEn` port are present.
- Not defined:
  - `iAutoEn` is still present but ignored.
  - No auto counter; `oMode` changes only through manual requests.

## Structure
- Shared package `image_pkg`:
  - State encoding (`WAIT_FRAME`, `IN_FRAME`, `COMMIT`).
  - `MODE_W` = 3, `MODE_BLANK` = 7, `MODE_LAST_ACTIVE` = 6, `FRAME_CNT_W` = 12.
- Natural sub-module `frame_edge_detect`: registers `iLineValid` and emits rise and fall pulses.
- All other logic stays flat.

## Test plan
- Reset with `RESET_MODE`=3, release:
  - `oMode`=3, `oPending`=0, `oFrameCount`=0.
- Strobe `iReqMode`=5 mid-frame:
  - `oPending`=1 next cycle.
  - `oMode` stays 3 until 1 cycle after the `COMMIT` cycle, then `oMode`=5 and `oSwitched` pulses once.
- Two strobes (2, then 4) in one frame:
  - Only 4 commits at frame end; exactly one `oSwitched` pulse.
- Strobe in blanking with `iLineValid` low:
  - `oMode` updates 1 cycle after the strobe edge.
- Strobe in the same cycle `iLineValid` rises:
  - No commit during that frame; commits at its end.
- `MODE_SEQ_AUTO_EN`, `FRAME_DIV`=2, `iAutoEn`=1, start `oMode`=6:
  - After 2 frames `oMode`=0; after 4 frames `oMode`=1.
  - A manual request of 7 during the count wins and resets the auto counter.
  - 2 frames later `oMode`=0.
